// File: rtl/mlp_seq_classifier.sv
// Two-layer perceptron classifier built around one shared multiply-accumulate unit.
// Weights are streamed from a writable register file, one term per clock cycle.
module mlp_seq_classifier #(
  parameter int N_IN  = 8,
  parameter int N_HID = 4,
  parameter int N_CLS = 10,
  parameter int WW    = 6,
  parameter int HW    = 8,
  parameter int AW    = 16,
  localparam int NW1  = N_HID * (N_IN + 1),
  localparam int NW   = NW1 + N_CLS * (N_HID + 1),
  localparam int ADW  = $clog2(NW),
  localparam int CW   = $clog2(N_CLS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [N_IN-1:0]      x,
  input  logic                 relu_en,
  input  logic                 wr_en,
  input  logic [ADW-1:0]       wr_addr,
  input  logic signed [WW-1:0] wr_data,
  output logic                 busy,
  output logic                 done,
  output logic [CW-1:0]        class_out,
  output logic signed [AW-1:0] score_out
);

  localparam int SMAX = (N_IN > N_HID) ? N_IN : N_HID;
  localparam int GMAX = (N_HID > N_CLS) ? N_HID : N_CLS;
  localparam int SW   = $clog2(SMAX + 1);
  localparam int GW   = $clog2(GMAX);
  localparam int XIW  = $clog2(N_IN);
  localparam int HIW  = $clog2(N_HID);

  localparam logic [SW-1:0] SUB_L1_LAST = SW'(N_IN);
  localparam logic [SW-1:0] SUB_L2_LAST = SW'(N_HID);
  localparam logic [GW-1:0] GRP_L1_LAST = GW'(N_HID - 1);
  localparam logic [GW-1:0] GRP_L2_LAST = GW'(N_CLS - 1);
  localparam logic signed [AW-1:0] H_MAX = AW'((2 ** (HW - 1)) - 1);
  localparam logic signed [AW-1:0] H_MIN = -H_MAX - AW'(1);

  typedef enum logic [1:0] {IDLE, L1, L2} state_t;

  state_t                state;
  logic signed [WW-1:0]  w_mem [NW];
  logic signed [HW-1:0]  h_reg [N_HID];
  logic [N_IN-1:0]       x_lat;
  logic                  relu_lat;
  logic [ADW-1:0]        idx;
  logic [SW-1:0]         sub;
  logic [GW-1:0]         grp;
  logic signed [AW-1:0]  acc;
  logic signed [AW-1:0]  best;
  logic [CW-1:0]         best_cls;

  logic signed [WW-1:0]  w_cur;
  logic signed [AW-1:0]  w_ext;
  logic signed [AW-1:0]  h_ext;
  logic signed [AW-1:0]  term;
  logic signed [AW-1:0]  sum;
  logic signed [AW-1:0]  act;
  logic signed [HW-1:0]  h_new;
  logic                  better;

  // One MAC term per cycle: the weight at idx scaled by its input or hidden value.
  always_comb begin
    w_cur  = w_mem[idx];
    w_ext  = {{(AW-WW){w_cur[WW-1]}}, w_cur};
    h_ext  = {{(AW-HW){h_reg[sub[HIW-1:0]][HW-1]}}, h_reg[sub[HIW-1:0]]};
    term   = '0;
    if (state == L1) begin
      if (sub == SUB_L1_LAST || x_lat[sub[XIW-1:0]]) term = w_ext;
    end else if (state == L2) begin
      if (sub == SUB_L2_LAST) term = w_ext;
      else                    term = w_ext * h_ext;
    end
    sum    = acc + term;
    act    = (relu_lat && sum < 0) ? '0 : sum;
    if (act > H_MAX)      h_new = H_MAX[HW-1:0];
    else if (act < H_MIN) h_new = H_MIN[HW-1:0];
    else                  h_new = act[HW-1:0];
    better = (grp == '0) || (sum > best);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      class_out <= '0;
      score_out <= '0;
      x_lat     <= '0;
      relu_lat  <= 1'b0;
      idx       <= '0;
      sub       <= '0;
      grp       <= '0;
      acc       <= '0;
      best      <= '0;
      best_cls  <= '0;
      for (int i = 0; i < NW; i++)    w_mem[i] <= '0;
      for (int j = 0; j < N_HID; j++) h_reg[j] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_en && 32'(wr_addr) < NW) w_mem[wr_addr] <= wr_data;
          if (start) begin
            state    <= L1;
            busy     <= 1'b1;
            x_lat    <= x;
            relu_lat <= relu_en;
            idx      <= '0;
            sub      <= '0;
            grp      <= '0;
            acc      <= '0;
          end
        end
        L1: begin
          idx <= idx + ADW'(1);
          if (sub == SUB_L1_LAST) begin
            h_reg[grp[HIW-1:0]] <= h_new;
            acc <= '0;
            sub <= '0;
            if (grp == GRP_L1_LAST) begin
              grp   <= '0;
              state <= L2;
            end else begin
              grp <= grp + GW'(1);
            end
          end else begin
            acc <= sum;
            sub <= sub + SW'(1);
          end
        end
        L2: begin
          idx <= idx + ADW'(1);
          if (sub == SUB_L2_LAST) begin
            acc <= '0;
            sub <= '0;
            if (better) begin
              best     <= sum;
              best_cls <= grp[CW-1:0];
            end
            if (grp == GRP_L2_LAST) begin
              // Final class: publish the post-compare winner directly.
              class_out <= better ? grp[CW-1:0] : best_cls;
              score_out <= better ? sum : best;
              done      <= 1'b1;
              busy      <= 1'b0;
              idx       <= '0;
              grp       <= '0;
              state     <= IDLE;
            end else begin
              grp <= grp + GW'(1);
            end
          end else begin
            acc <= sum;
            sub <= sub + SW'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
